// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one data-memory port among
// num_req_p cores using the valid/yumi handshake of mem_in_s/mem_out_s.
// It serves one transaction at a time: IDLE -> REQ -> RESP -> IDLE.
// Optional feature macro: DMEM_ARB_WATCHDOG_EN adds a watchdog that forces
// a stuck grant back to IDLE after watchdog_limit_p cycles and raises a
// sticky timeout_o flag.

package dmem_arbiter_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] read_data;
    logic        yumi;
  } mem_out_s;

endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int num_req_p        = 4,
  parameter int req_id_width_p   = $clog2(num_req_p),
  parameter int watchdog_limit_p = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  mem_in_s                     req_i [num_req_p],
  input  logic [num_req_p-1:0][31:0]  req_addr_i,
  output mem_out_s                    resp_o [num_req_p],
  output mem_in_s                     mem_o,
  output logic [31:0]                 mem_addr_o,
  input  mem_out_s                    mem_i,
  output logic [num_req_p-1:0]        grant_o,
  output logic                        timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic [num_req_p-1:0] grant_one_p = num_req_p'(1);

  state_t                    state;
  logic [req_id_width_p-1:0] ptr_r;
  logic [req_id_width_p-1:0] owner_r;

  logic                      hit;
  logic [req_id_width_p-1:0] hit_id;
  logic [req_id_width_p-1:0] scan_id;

  mem_in_s                   own_req;
  logic [31:0]               own_addr;
  logic                      wd_fire;

  // Wraps explicitly at num_req_p-1 so non-power-of-2 core counts work.
  function automatic logic [req_id_width_p-1:0] next_id(
    input logic [req_id_width_p-1:0] id
  );
    if (id == req_id_width_p'(num_req_p - 1)) begin
      return '0;
    end
    return id + req_id_width_p'(1);
  endfunction

  assign own_req  = req_i[owner_r];
  assign own_addr = req_addr_i[owner_r];

`ifdef DMEM_ARB_WATCHDOG_EN
  localparam int wd_width_p = $clog2(watchdog_limit_p + 1);

  logic [wd_width_p-1:0] wd_count;
  logic                  timeout_r;

  assign wd_fire   = (state != IDLE) && (wd_count == wd_width_p'(watchdog_limit_p - 1));
  assign timeout_o = timeout_r;

  // Counts cycles spent holding a grant; latches a sticky timeout when it expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count  <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state == IDLE || wd_fire) begin
        wd_count <= '0;
      end else begin
        wd_count <= wd_count + wd_width_p'(1);
      end
      if (wd_fire) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_wd_limit;

  assign unused_wd_limit = 32'(watchdog_limit_p);
  assign wd_fire         = 1'b0;
  assign timeout_o       = 1'b0;
`endif

  // Round-robin scan of request valids, starting at the priority pointer.
  always_comb begin
    hit     = 1'b0;
    hit_id  = ptr_r;
    scan_id = ptr_r;
    for (int i = 0; i < num_req_p; i++) begin
      if (!hit && req_i[scan_id].valid) begin
        hit    = 1'b1;
        hit_id = scan_id;
      end
      scan_id = next_id(scan_id);
    end
  end

  // Arbitration FSM: grants, tracks the owner and rotates priority on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            owner_r <= hit_id;
            grant_o <= grant_one_p << hit_id;
            state   <= REQ;
          end
        end
        REQ: begin
          if (wd_fire) begin
            state   <= IDLE;
            ptr_r   <= next_id(owner_r);
            grant_o <= '0;
          end else if (mem_i.yumi) begin
            if (mem_i.valid && own_req.yumi) begin
              state   <= IDLE;
              ptr_r   <= next_id(owner_r);
              grant_o <= '0;
            end else begin
              state <= RESP;
            end
          end else if (!own_req.valid) begin
            state   <= IDLE;
            ptr_r   <= next_id(owner_r);
            grant_o <= '0;
          end
        end
        RESP: begin
          if (wd_fire || (mem_i.valid && own_req.yumi)) begin
            state   <= IDLE;
            ptr_r   <= next_id(owner_r);
            grant_o <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

  // Routes the owner's request to memory and the memory's reply to the owner only.
  always_comb begin
    mem_o      = '0;
    mem_addr_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      resp_o[k] = '0;
    end
    case (state)
      REQ: begin
        if (!wd_fire) begin
          mem_o                   = own_req;
          mem_addr_o              = own_addr;
          resp_o[owner_r].yumi    = mem_i.yumi;
          if (mem_i.yumi) begin
            resp_o[owner_r].valid     = mem_i.valid;
            resp_o[owner_r].read_data = mem_i.read_data;
          end
        end
      end
      RESP: begin
        if (!wd_fire) begin
          mem_o.yumi                = own_req.yumi;
          mem_addr_o                = own_addr;
          resp_o[owner_r].valid     = mem_i.valid;
          resp_o[owner_r].read_data = mem_i.read_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with four
// cores. The watchdog steps are built only when DMEM_ARB_WATCHDOG_EN is defined.

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  mem_in_s             req_i [4];
  logic [3:0][31:0]    req_addr_i;
  mem_out_s            resp_o [4];
  mem_in_s             mem_o;
  logic [31:0]         mem_addr_o;
  mem_out_s            mem_i;
  logic [3:0]          grant_o;
  logic                timeout_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] addr_tab [4];

  dmem_arbiter #(
    .num_req_p        (4),
    .watchdog_limit_p (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .resp_o     (resp_o),
    .mem_o      (mem_o),
    .mem_addr_o (mem_addr_o),
    .mem_i      (mem_i),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      req_i[k] = '0;
    end
    mem_i = '0;
  endtask

  initial begin
    addr_tab[0] = 32'h0000_1000;
    addr_tab[1] = 32'h0000_1010;
    addr_tab[2] = 32'h0000_0040;
    addr_tab[3] = 32'h0000_1030;
    for (int k = 0; k < 4; k++) begin
      req_addr_i[k] = addr_tab[k];
    end
    clear_inputs();
    reset = 1'b0;
    #2;
    check("reset_grant", 64'(grant_o), 64'h0);
    check("reset_timeout", 64'(timeout_o), 64'h0);
    check("reset_mem_o", 64'(mem_o), 64'h0);
    check("reset_mem_addr", 64'(mem_addr_o), 64'h0);
    check("reset_resp0", 64'(resp_o[0]), 64'h0);
    tick();
    tick();
    reset = 1'b1;

    // Single read by core 2.
    req_i[2].valid = 1'b1;
    settle();
    check("single_idle_grant", 64'(grant_o), 64'h0);
    tick();
    check("single_grant", 64'(grant_o), 64'h4);
    check("single_mem_valid", 64'(mem_o.valid), 64'h1);
    check("single_mem_addr", 64'(mem_addr_o), 64'h40);
    tick();
    check("single_wait_grant", 64'(grant_o), 64'h4);
    check("single_wait_yumi", 64'(resp_o[2].yumi), 64'h0);
    mem_i.yumi = 1'b1;
    settle();
    check("single_yumi_owner", 64'(resp_o[2].yumi), 64'h1);
    check("single_yumi_other", 64'(resp_o[0].yumi), 64'h0);
    tick();
    mem_i.yumi      = 1'b0;
    mem_i.valid     = 1'b1;
    mem_i.read_data = 32'hDEAD_BEEF;
    req_i[2].valid  = 1'b0;
    req_i[2].yumi   = 1'b1;
    settle();
    check("single_rdata_owner", 64'(resp_o[2].read_data), 64'hDEAD_BEEF);
    check("single_rvalid_owner", 64'(resp_o[2].valid), 64'h1);
    check("single_resp_other1", 64'(resp_o[1]), 64'h0);
    check("single_rdata_other3", 64'(resp_o[3].read_data), 64'h0);
    check("single_resp_mem_valid", 64'(mem_o.valid), 64'h0);
    check("single_resp_mem_yumi", 64'(mem_o.yumi), 64'h1);
    tick();
    clear_inputs();
    settle();
    check("single_done_grant", 64'(grant_o), 64'h0);
    check("single_done_mem_o", 64'(mem_o), 64'h0);
    check("single_done_resp2", 64'(resp_o[2]), 64'h0);

    // Contention between cores 0 and 3 right after reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_i[0].valid = 1'b1;
    req_i[3].valid = 1'b1;
    tick();
    check("cont_first_grant", 64'(grant_o), 64'h1);
    check("cont_first_addr", 64'(mem_addr_o), 64'h1000);
    mem_i.yumi = 1'b1;
    tick();
    mem_i           = '0;
    mem_i.valid     = 1'b1;
    mem_i.read_data = 32'h1111_0000;
    req_i[0].valid  = 1'b0;
    req_i[0].yumi   = 1'b1;
    settle();
    check("cont_first_rdata", 64'(resp_o[0].read_data), 64'h1111_0000);
    tick();
    mem_i         = '0;
    req_i[0].yumi = 1'b0;
    settle();
    check("cont_idle_gap", 64'(grant_o), 64'h0);
    tick();
    check("cont_second_grant", 64'(grant_o), 64'h8);
    check("cont_second_addr", 64'(mem_addr_o), 64'h1030);

    // Same-cycle acknowledge completes core 3 straight from REQ.
    mem_i.yumi      = 1'b1;
    mem_i.valid     = 1'b1;
    mem_i.read_data = 32'hCAFE_F00D;
    req_i[3].yumi   = 1'b1;
    settle();
    check("same_yumi", 64'(resp_o[3].yumi), 64'h1);
    check("same_rdata", 64'(resp_o[3].read_data), 64'hCAFE_F00D);
    tick();
    clear_inputs();
    settle();
    check("same_back_idle", 64'(grant_o), 64'h0);
    check("same_mem_o_idle", 64'(mem_o), 64'h0);

    // Wrap-around: all cores request continuously, priority starts at 0.
    for (int k = 0; k < 4; k++) begin
      req_i[k].valid = 1'b1;
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      check("wrap_grant", 64'(grant_o), 64'(4'b0001 << (t % 4)));
      check("wrap_addr", 64'(mem_addr_o), 64'(addr_tab[t % 4]));
      mem_i.yumi             = 1'b1;
      mem_i.valid            = 1'b1;
      req_i[t % 4].yumi      = 1'b1;
      tick();
      mem_i                  = '0;
      req_i[t % 4].yumi      = 1'b0;
      settle();
      check("wrap_gap", 64'(grant_o), 64'h0);
    end

    // Abandon: core 1 drops valid before memory accepts.
    clear_inputs();
    req_i[1].valid = 1'b1;
    tick();
    check("abandon_grant", 64'(grant_o), 64'h2);
    req_i[1].valid = 1'b0;
    tick();
    check("abandon_idle", 64'(grant_o), 64'h0);
    req_i[0].valid = 1'b1;
    req_i[1].valid = 1'b1;
    req_i[2].valid = 1'b1;
    tick();
    check("abandon_next_grant", 64'(grant_o), 64'h4);
    mem_i.yumi    = 1'b1;
    mem_i.valid   = 1'b1;
    req_i[2].yumi = 1'b1;
    tick();
    clear_inputs();

    // Reset asserted while core 1 is in RESP.
    req_i[1].valid = 1'b1;
    tick();
    check("midrst_grant", 64'(grant_o), 64'h2);
    mem_i.yumi = 1'b1;
    tick();
    mem_i.yumi      = 1'b0;
    req_i[1].valid  = 1'b0;
    mem_i.valid     = 1'b1;
    mem_i.read_data = 32'h0000_5A5A;
    settle();
    check("midrst_resp_valid", 64'(resp_o[1].valid), 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_grant_zero", 64'(grant_o), 64'h0);
    check("midrst_mem_o_zero", 64'(mem_o), 64'h0);
    check("midrst_resp1_zero", 64'(resp_o[1]), 64'h0);
    tick();
    reset = 1'b1;
    clear_inputs();
    req_i[0].valid = 1'b1;
    req_i[3].valid = 1'b1;
    tick();
    check("midrst_core0_first", 64'(grant_o), 64'h1);

`ifdef DMEM_ARB_WATCHDOG_EN
    // Memory never accepts: watchdog frees the grant after 10 cycles.
    for (int c = 0; c < 9; c++) begin
      tick();
    end
    check("wd_before_timeout", 64'(timeout_o), 64'h0);
    check("wd_before_grant", 64'(grant_o), 64'h1);
    tick();
    check("wd_timeout", 64'(timeout_o), 64'h1);
    check("wd_forced_idle", 64'(grant_o), 64'h0);
    tick();
    check("wd_next_grant", 64'(grant_o), 64'h8);
    check("wd_sticky", 64'(timeout_o), 64'h1);
`else
    // Without the watchdog the grant waits indefinitely.
    for (int c = 0; c < 12; c++) begin
      tick();
    end
    check("nowd_timeout", 64'(timeout_o), 64'h0);
    check("nowd_grant_held", 64'(grant_o), 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares one data-memory port among `num_req_p` cores, each speaking the core's `mem_in_s`/`mem_out_s` valid/yumi handshake. It sits between the cores' `to_mem_o`/`data_mem_addr`/`from_mem_i` and the single data memory. It grants one core at a time and forwards that core's request. It routes the memory's acknowledge and response back to the granted core only, then rotates priority.

## Interface
- `num_req_p`, default 4: number of requesting cores, ≥2.
- `req_id_width_p`, default `$clog2(num_req_p)`: width of the owner index.
- `watchdog_limit_p`, default 255: cycles a grant may stay outstanding; used only with `DMEM_ARB_WATCHDOG_EN`.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_i`, input, `mem_in_s [num_req_p]`: per-core request (`write_data`, `valid`, `wen`, `byte_not_word`, `yumi`).
- `req_addr_i`, input, `[num_req_p][31:0]`: per-core `data_mem_addr`.
- `resp_o`, output, `mem_out_s [num_req_p]`: per-core response (`valid`, `read_data`, `yumi`).
- `mem_o`, output, `mem_in_s`: request to data memory.
- `mem_addr_o`, output, 32: address to data memory.
- `mem_i`, input, `mem_out_s`: data memory response.
- `grant_o`, output, `num_req_p`: one-hot current owner; all zeros in IDLE.
- `timeout_o`, output, 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - Scan `req_i[k].valid` starting at `ptr_r` and wrapping modulo `num_req_p`.
  - Register the first hit as `owner_r`, set `grant_o`, go to REQ.
  - No hit: stay in IDLE.
- **REQ**
  - Drive `mem_o = req_i[owner_r]` and `mem_addr_o = req_addr_i[owner_r]`.
  - Drive `resp_o[owner_r].yumi = mem_i.yumi`.
  - On `mem_i.yumi`, go to RESP.
  - If `mem_i.yumi`, `mem_i.valid` and `req_i[owner_r].yumi` are all 1 in the same cycle, complete directly and go to IDLE.
  - If `req_i[owner_r].valid` drops before `mem_i.yumi`, abandon the request: go to IDLE, `ptr_r ← owner_r+1`.
- **RESP**
  - Drive `mem_o.valid = 0`. Drive `mem_o.yumi = req_i[owner_r].yumi`.
  - Drive `resp_o[owner_r].valid = mem_i.valid` and `resp_o[owner_r].read_data = mem_i.read_data`.
  - On `mem_i.valid & req_i[owner_r].yumi`: go to IDLE, `ptr_r ← owner_r+1`.
- **Non-owner outputs:** non-owners always see `resp_o[k] = '0`, with `valid`, `yumi` and `read_data` all 0.
- **Outputs in IDLE:** `mem_o = '0` and `mem_addr_o = 0`.
- **Pointer arithmetic:** `ptr_r` wraps `num_req_p-1 → 0`. For a non-power-of-2 `num_req_p`, compare explicitly against `num_req_p-1`; never rely on natural overflow.
- **At most one transaction is outstanding.** No pipelining across owners.

## Timing
- **Reset values (reset=0, asynchronous):**
  - state = IDLE, `ptr_r = 0`, `owner_r = 0`
  - `grant_o = 0`, `timeout_o = 0`, watchdog count = 0
  - `mem_o = '0`, `resp_o = '0`
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge N is forwarded on `mem_o` during cycle N+1.
- **Owner change:** a new owner cannot be granted in the same cycle the previous one completes. At least 1 IDLE cycle separates grants.
- **Core side:** every core observes the same handshake it would see with a private memory, stretched by the arbitration cycle and by waiting for other owners.
- **Reset mid-transaction:** the FSM aborts immediately. The memory-side transaction is not completed; memory is reset with the arbiter.

## Configuration
- **`DMEM_ARB_WATCHDOG_EN` defined:**
  - A counter increments each cycle in REQ or RESP and clears on entry to IDLE.
  - When it reaches `watchdog_limit_p`: set `timeout_o` (sticky until reset), force the FSM to IDLE, and set `ptr_r ← owner_r+1`.
  - `resp_o[owner_r]` stays 0 for the forced cycle.
- **Undefined:** no counter is built, `timeout_o` is tied to 0, and REQ/RESP wait indefinitely.

## Test plan
- **Single read:** core 2 raises valid (addr 0x40) and memory yumis 2 cycles later → `grant_o` = 0100 one cycle after valid, `resp_o[2].yumi` pulses with `mem_i.yumi`, and `read_data` 0xDEADBEEF reaches core 2 only.
- **Contention:** cores 0 and 3 request in the same cycle from reset → core 0 is served first, then core 3, with exactly one IDLE cycle between the grants.
- **Wrap-around:** all 4 cores request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- **Same-cycle acknowledge:** `mem_i.yumi` and `mem_i.valid` arrive together with core yumi → FSM goes REQ → IDLE in that single cycle, and `ptr_r` advances.
- **Reset mid-transaction:** reset is asserted while in RESP → `grant_o`, `mem_o` and `resp_o` go to 0 asynchronously. After release, core 0 has priority.
- **Watchdog** (macro on, `watchdog_limit_p` = 10): memory never yumis → `timeout_o` rises after 10 cycles in REQ, and the next pending core is granted.
